// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done handshake and operand/result bundle for shift_sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 17,
    parameter int AMT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             direction;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic [AMT_W-1:0] remaining;
    modport master (output start, data_in, amount, direction, input busy, done, data_out, remaining);
    modport slave  (input start, data_in, amount, direction, output busy, done, data_out, remaining);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: N-bit shifter built from one single-bit stage applied once per clock.
module shift_step #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] in,
    input  logic             direction,
    output logic [WIDTH-1:0] out
);
    assign out = direction ? {in[WIDTH-2:0], 1'b0} : {in[WIDTH-1], in[WIDTH-1:1]};
endmodule

module shift_sequencer #(
    parameter int WIDTH = 17,
    parameter int AMT_W = 5
) (
    input logic               clk,
    input logic               rst,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);
    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, shifted;
    logic             dir_q;
    logic [AMT_W-1:0] rem, eff;
    // Beyond WIDTH steps the result is saturated, so the latency is capped there.
    assign eff = (bus.amount >= W_AMT) ? W_AMT : bus.amount;
    shift_step #(.WIDTH(WIDTH)) u_step (.in(acc), .direction(dir_q), .out(shifted));
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE)  ? (bus.start ? ((eff == '0) ? DONE : SHIFT) : IDLE) :
                   (state == SHIFT) ? ((rem == AMT_W'(1)) ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            dir_q <= 1'b0;
            rem   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                acc   <= bus.data_in;
                dir_q <= bus.direction;
                rem   <= eff;
            end else if (state == SHIFT) begin
                acc <= shifted;
                rem <= rem - AMT_W'(1);
            end
        end
    end
    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.data_out  = acc;
    assign bus.remaining = rem;
endmodule
